// File: rtl/axi_slave_mem.sv
// Single-beat AXI memory responder with independent write (AW/W->B) and read (AR->R) FSMs.
// Optional out-of-range SLVERR responses when AXI_SLAVE_ERR_RESP_EN is defined.
module axi_slave_mem #(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_WIDTH-1:0]   S_AWID,
    input  logic [ADDR_WIDTH-1:0] S_AWADDR,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,
    input  logic [BUS_WIDTH-1:0]  S_WDATA,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    output logic [ID_WIDTH-1:0]   S_BID,
    output logic [1:0]            S_BRESP,
    output logic                  S_BVALID,
    input  logic                  S_BREADY,
    input  logic [ID_WIDTH-1:0]   S_ARID,
    input  logic [ADDR_WIDTH-1:0] S_ARADDR,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,
    output logic [ID_WIDTH-1:0]   S_RID,
    output logic [BUS_WIDTH-1:0]  S_RDATA,
    output logic [1:0]            S_RRESP,
    output logic                  S_RVALID,
    input  logic                  S_RREADY
);
    localparam int unsigned LSB  = $clog2(BUS_WIDTH / 8);
    localparam int unsigned IDXW = $clog2(DEPTH);

    typedef enum logic {WIDLE, WRESP} wstate_t;
    typedef enum logic {RIDLE, RDATA} rstate_t;

    wstate_t                r_wstate, w_wstate_nxt;
    rstate_t                r_rstate, w_rstate_nxt;
    logic [BUS_WIDTH-1:0]   r_mem [DEPTH];

    logic                   r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [ID_WIDTH-1:0]    r_bid, r_rid, r_aw_id;
    logic [1:0]             r_bresp, r_rresp;
    logic [BUS_WIDTH-1:0]   r_rdata, r_wdata;
    logic                   r_aw_got, r_w_got, r_aw_oor;
    logic [IDXW-1:0]        r_aw_idx;

    logic                   w_awready_nxt, w_wready_nxt, w_bvalid_nxt, w_arready_nxt, w_rvalid_nxt;
    logic [ID_WIDTH-1:0]    w_bid_nxt, w_rid_nxt, w_aw_id_nxt;
    logic [1:0]             w_bresp_nxt, w_rresp_nxt;
    logic [BUS_WIDTH-1:0]   w_rdata_nxt, w_wdata_nxt;
    logic                   w_aw_got_nxt, w_w_got_nxt, w_aw_oor_nxt, w_mem_we;
    logic [IDXW-1:0]        w_aw_idx_nxt;
    logic                   w_awaddr_oor, w_araddr_oor;
    logic [IDXW-1:0]        w_aw_idx, w_ar_idx;
    logic                   w_unused_addr;

    assign w_aw_idx = S_AWADDR[LSB +: IDXW];
    assign w_ar_idx = S_ARADDR[LSB +: IDXW];
    assign w_unused_addr = ^{S_AWADDR, S_ARADDR};

`ifdef AXI_SLAVE_ERR_RESP_EN
    // Any set bit above the index field marks the access out of range
    assign w_awaddr_oor = (S_AWADDR >> (LSB + IDXW)) != '0;
    assign w_araddr_oor = (S_ARADDR >> (LSB + IDXW)) != '0;
`else
    assign w_awaddr_oor = 1'b0;
    assign w_araddr_oor = 1'b0;
`endif

    assign S_AWREADY = r_awready;
    assign S_WREADY  = r_wready;
    assign S_BVALID  = r_bvalid;
    assign S_BID     = r_bid;
    assign S_BRESP   = r_bresp;
    assign S_ARREADY = r_arready;
    assign S_RVALID  = r_rvalid;
    assign S_RID     = r_rid;
    assign S_RDATA   = r_rdata;
    assign S_RRESP   = r_rresp;

    // Write FSM next state: collect AW and W in any order, commit when both present
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bid_nxt     = r_bid;
        w_bresp_nxt   = r_bresp;
        w_aw_got_nxt  = r_aw_got;
        w_w_got_nxt   = r_w_got;
        w_aw_idx_nxt  = r_aw_idx;
        w_aw_oor_nxt  = r_aw_oor;
        w_aw_id_nxt   = r_aw_id;
        w_wdata_nxt   = r_wdata;
        w_mem_we      = 1'b0;
        case (r_wstate)
            WIDLE: begin
                if (S_AWVALID && r_awready) begin
                    w_aw_got_nxt  = 1'b1;
                    w_aw_idx_nxt  = w_aw_idx;
                    w_aw_oor_nxt  = w_awaddr_oor;
                    w_aw_id_nxt   = S_AWID;
                    w_awready_nxt = 1'b0;
                end
                if (S_WVALID && r_wready) begin
                    w_w_got_nxt  = 1'b1;
                    w_wdata_nxt  = S_WDATA;
                    w_wready_nxt = 1'b0;
                end
                if (w_aw_got_nxt && w_w_got_nxt) begin
                    w_mem_we      = !w_aw_oor_nxt;
                    w_wstate_nxt  = WRESP;
                    w_bvalid_nxt  = 1'b1;
                    w_bid_nxt     = w_aw_id_nxt;
                    w_bresp_nxt   = w_aw_oor_nxt ? 2'b10 : 2'b00;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b0;
                    w_aw_got_nxt  = 1'b0;
                    w_w_got_nxt   = 1'b0;
                end
            end
            WRESP: begin
                if (S_BREADY) begin
                    w_wstate_nxt  = WIDLE;
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end
            end
            default: w_wstate_nxt = WIDLE;
        endcase
    end

    // Read FSM next state: memory sampled before any same-edge write lands
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rid_nxt     = r_rid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_rstate)
            RIDLE: begin
                if (S_ARVALID && r_arready) begin
                    w_rstate_nxt  = RDATA;
                    w_arready_nxt = 1'b0;
                    w_rvalid_nxt  = 1'b1;
                    w_rid_nxt     = S_ARID;
                    w_rdata_nxt   = w_araddr_oor ? '0 : r_mem[w_ar_idx];
                    w_rresp_nxt   = w_araddr_oor ? 2'b10 : 2'b00;
                end
            end
            RDATA: begin
                if (S_RREADY) begin
                    w_rstate_nxt  = RIDLE;
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                end
            end
            default: w_rstate_nxt = RIDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate  <= WIDLE;
            r_rstate  <= RIDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= 2'b00;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_oor  <= 1'b0;
            r_aw_id   <= '0;
            r_wdata   <= '0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_rstate  <= w_rstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bid     <= w_bid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_aw_got  <= w_aw_got_nxt;
            r_w_got   <= w_w_got_nxt;
            r_aw_idx  <= w_aw_idx_nxt;
            r_aw_oor  <= w_aw_oor_nxt;
            r_aw_id   <= w_aw_id_nxt;
            r_wdata   <= w_wdata_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rid     <= w_rid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_mem_we) begin
            r_mem[w_aw_idx_nxt] <= w_wdata_nxt;
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem (default DEPTH 16, 32-bit data).
`timescale 1ns/1ps
module tb_axi_slave_mem;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  S_AWID, S_BID, S_ARID, S_RID;
    logic [31:0] S_AWADDR, S_ARADDR, S_WDATA, S_RDATA;
    logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic        S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
    logic [1:0]  S_BRESP, S_RRESP;
    int          tests = 0;
    int          fails = 0;

    always #5 ACLK = ~ACLK;

    axi_slave_mem dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID),
        .S_RREADY(S_RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // AW+W in the same cycle with BREADY high; checks B beat and return to idle
    task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] id,
                      input logic [31:0] d, input logic [1:0] resp);
        S_AWADDR = a; S_AWID = id; S_AWVALID = 1'b1;
        S_WDATA = d; S_WVALID = 1'b1; S_BREADY = 1'b1;
        tick;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        chk({tag, ".bvalid"}, 64'(S_BVALID), 64'd1);
        chk({tag, ".bid"}, 64'(S_BID), 64'(id));
        chk({tag, ".bresp"}, 64'(S_BRESP), 64'(resp));
        chk({tag, ".awready_busy"}, 64'(S_AWREADY), 64'd0);
        tick;
        chk({tag, ".bvalid_drop"}, 64'(S_BVALID), 64'd0);
        chk({tag, ".readies_back"}, 64'({S_AWREADY, S_WREADY}), 64'h3);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] id,
                      input logic [31:0] d, input logic [1:0] resp);
        S_ARADDR = a; S_ARID = id; S_ARVALID = 1'b1; S_RREADY = 1'b1;
        tick;
        S_ARVALID = 1'b0;
        chk({tag, ".rvalid"}, 64'(S_RVALID), 64'd1);
        chk({tag, ".rid"}, 64'(S_RID), 64'(id));
        chk({tag, ".rdata"}, 64'(S_RDATA), 64'(d));
        chk({tag, ".rresp"}, 64'(S_RRESP), 64'(resp));
        chk({tag, ".arready_busy"}, 64'(S_ARREADY), 64'd0);
        tick;
        chk({tag, ".rvalid_drop"}, 64'(S_RVALID), 64'd0);
        chk({tag, ".arready_back"}, 64'(S_ARREADY), 64'd1);
    endtask

    initial begin
        ARESETn = 1'b0;
        S_AWID = '0; S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WVALID = 1'b0;
        S_BREADY = 1'b0; S_ARID = '0; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;
        tick; tick;
        chk("rst.readies", 64'({S_AWREADY, S_WREADY, S_ARREADY}), 64'h7);
        chk("rst.valids", 64'({S_BVALID, S_RVALID}), 64'h0);
        chk("rst.ids_data", 64'({S_BID, S_RID, S_BRESP, S_RRESP}), 64'h0);
        chk("rst.rdata", 64'(S_RDATA), 64'h0);
        ARESETn = 1'b1;
        tick;

        wr("w_c", 32'h0000_000C, 4'd3, 32'h1234_5678, 2'b00);
        rd("r_c", 32'h0000_000C, 4'd5, 32'h1234_5678, 2'b00);

        // W leads AW by two cycles; write commits on the AW edge
        S_WDATA = 32'hAABB_CCDD; S_WVALID = 1'b1; S_BREADY = 1'b1;
        tick;
        S_WVALID = 1'b0;
        chk("wfirst.wready_low", 64'(S_WREADY), 64'd0);
        chk("wfirst.awready_high", 64'(S_AWREADY), 64'd1);
        tick;
        chk("wfirst.no_b", 64'(S_BVALID), 64'd0);
        S_AWADDR = 32'h4; S_AWID = 4'd7; S_AWVALID = 1'b1;
        tick;
        S_AWVALID = 1'b0;
        chk("wfirst.bvalid", 64'(S_BVALID), 64'd1);
        chk("wfirst.bid", 64'(S_BID), 64'd7);
        tick;
        chk("wfirst.bdone", 64'(S_BVALID), 64'd0);
        rd("r_4", 32'h4, 4'd1, 32'hAABB_CCDD, 2'b00);

        // B backpressure for five cycles
        S_AWADDR = 32'h0; S_AWID = 4'd9; S_AWVALID = 1'b1;
        S_WDATA = 32'h1111_2222; S_WVALID = 1'b1; S_BREADY = 1'b0;
        tick;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall.bvalid", 64'(S_BVALID), 64'd1);
            chk("stall.bid", 64'(S_BID), 64'd9);
            chk("stall.readies", 64'({S_AWREADY, S_WREADY}), 64'h0);
            tick;
        end
        S_BREADY = 1'b1;
        tick;
        chk("stall.released", 64'({S_BVALID, S_AWREADY, S_WREADY}), 64'h3);

        // AR on the same edge as a write commit to the same index sees the old word
        S_AWADDR = 32'h8; S_AWID = 4'd2; S_AWVALID = 1'b1;
        S_WDATA = 32'hDEAD_BEEF; S_WVALID = 1'b1; S_BREADY = 1'b1;
        S_ARADDR = 32'h8; S_ARID = 4'd4; S_ARVALID = 1'b1; S_RREADY = 1'b1;
        tick;
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        chk("race.bvalid", 64'(S_BVALID), 64'd1);
        chk("race.rvalid", 64'(S_RVALID), 64'd1);
        chk("race.rdata_old", 64'(S_RDATA), 64'h0);
        tick;
        rd("race.r_new", 32'h8, 4'd6, 32'hDEAD_BEEF, 2'b00);

        // Address above the index field
`ifdef AXI_SLAVE_ERR_RESP_EN
        wr("oor.w", 32'h100, 4'd8, 32'h5566_7788, 2'b10);
        rd("oor.word0", 32'h0, 4'd8, 32'h1111_2222, 2'b00);
        rd("oor.r", 32'h100, 4'd3, 32'h0, 2'b10);
`else
        wr("wrap.w", 32'h100, 4'd8, 32'h5566_7788, 2'b00);
        rd("wrap.word0", 32'h0, 4'd8, 32'h5566_7788, 2'b00);
        rd("wrap.r", 32'h100, 4'd3, 32'h5566_7788, 2'b00);
`endif

        // Asynchronous reset during an outstanding B
        S_AWADDR = 32'hC; S_AWID = 4'hA; S_AWVALID = 1'b1;
        S_WDATA = 32'hCAFE_F00D; S_WVALID = 1'b1; S_BREADY = 1'b0;
        tick;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        chk("abort.pre_bvalid", 64'(S_BVALID), 64'd1);
        #2 ARESETn = 1'b0;
        #1;
        chk("abort.bvalid", 64'(S_BVALID), 64'd0);
        chk("abort.bid", 64'(S_BID), 64'd0);
        chk("abort.readies", 64'({S_AWREADY, S_WREADY, S_ARREADY}), 64'h7);
        tick;
        ARESETn = 1'b1;
        tick;
        rd("abort.mem_cleared", 32'hC, 4'd2, 32'h0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
